ysyx_22050019_ifu: RTL and testbench

Instruction fetch stage directly upstream of the IF/ID pipeline register. It owns the PC, issues one instruction read at a time on the core's simple address/data read bus, and selects the 32-bit instruction from the 64-bit read data. It presents pc/inst/commite to IF/ID and holds them while IF/ID is stalled. It accepts redirect (jump/flush) requests from ID and discards any in-flight fetch that the redirect makes stale.

---
 rtl/ysyx_22050019_ifu_pkg.sv | 20 ++
 rtl/ysyx_22050019_pc_reg.sv | 31 +++
 rtl/ysyx_22050019_ifu.sv | 128 ++++++++++++
 tb/tb_ysyx_22050019_ifu.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, the default reset PC and the word-select helper.
package ysyx_22050019_ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0000;

    // The bus returns an aligned 8-byte beat; PC bit 2 picks the 32-bit half.
    function automatic logic [31:0] sel_inst(input logic pc_bit2, input logic [63:0] beat);
        return pc_bit2 ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22050019_pc_reg.sv
// Program counter register.
// A redirect load wins over the sequential +4 advance; otherwise the PC holds.
module ysyx_22050019_pc_reg
    import ysyx_22050019_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_adv) begin
            r_pc <= r_pc + ADDR_W'(4);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: one outstanding read, presents pc/inst to IF/ID,
// and discards responses made stale by a redirect from ID.
module ysyx_22050019_ifu
    import ysyx_22050019_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_id_stall_i,
    input  logic              id_j_flush,
    input  logic [ADDR_W-1:0] jump_pc_i,
    output logic              ar_valid_o,
    output logic [ADDR_W-1:0] ar_addr_o,
    input  logic              ar_ready_i,
    input  logic              r_valid_i,
    input  logic [63:0]       r_data_i,
    output logic              r_ready_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              commite_o,
    output logic              ifu_ok_o,
    output logic [1:0]        dbg_state_o
);

    // Bus handshakes: a request transfers on the edge where ar_valid_o and
    // ar_ready_i are both high; a response transfers where r_valid_i and
    // r_ready_o are both high. Neither side may depend on the other combinationally.

    ifu_state_e        r_state, w_state_nxt;
    logic              r_kill, w_kill_nxt;
    logic              w_capture, w_clear, w_adv;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] r_pc_o;
    logic [31:0]       r_inst;
    logic              r_commite, r_ifu_ok;

    ysyx_22050019_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst_n),
        .i_load   (id_j_flush),
        .i_target (jump_pc_i),
        .i_adv    (w_adv),
        .o_pc     (w_pc)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = ADDR;
            ADDR: begin
                if (ar_ready_i) begin
                    w_state_nxt = DATA;
                    if (id_j_flush) w_kill_nxt = 1'b1;
                end
            end
            DATA: begin
                if (r_valid_i) begin
                    w_kill_nxt = 1'b0;
                    if (r_kill || id_j_flush) begin
                        w_state_nxt = ADDR;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (id_j_flush) begin
                    w_kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                // The redirect load inside pc_reg overrides the advance.
                if (id_j_flush || !if_id_stall_i) begin
                    w_clear     = 1'b1;
                    w_adv       = !if_id_stall_i;
                    w_state_nxt = ADDR;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pc_o    <= '0;
            r_inst    <= INST_NOP;
            r_commite <= 1'b0;
            r_ifu_ok  <= 1'b0;
        end else begin
            r_ifu_ok <= w_capture;
            if (w_capture) begin
                r_pc_o    <= w_pc;
                r_inst    <= sel_inst(w_pc[2], r_data_i);
                r_commite <= 1'b1;
            end else if (w_clear) begin
                r_inst    <= INST_NOP;
                r_commite <= 1'b0;
            end
        end
    end

    assign ar_valid_o  = (r_state == ADDR);
    assign ar_addr_o   = w_pc;
    assign r_ready_o   = (r_state == DATA);
    assign pc_o        = r_pc_o;
    assign inst_o      = r_inst;
    assign commite_o   = r_commite;
    assign ifu_ok_o    = r_ifu_ok;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Directed bench for the fetch unit: fetch, stall hold, redirects in each
// state, and asynchronous reset in the middle of a read.
module tb_ysyx_22050019_ifu;

    logic        clk;
    logic        rst_n;
    logic        if_id_stall_i;
    logic        id_j_flush;
    logic [63:0] jump_pc_i;
    logic        ar_valid_o;
    logic [63:0] ar_addr_o;
    logic        ar_ready_i;
    logic        r_valid_i;
    logic [63:0] r_data_i;
    logic        r_ready_o;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        commite_o;
    logic        ifu_ok_o;
    logic [1:0]  dbg_state_o;

    int total = 0;
    int bad   = 0;

    ysyx_22050019_ifu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_id_stall_i (if_id_stall_i),
        .id_j_flush    (id_j_flush),
        .jump_pc_i     (jump_pc_i),
        .ar_valid_o    (ar_valid_o),
        .ar_addr_o     (ar_addr_o),
        .ar_ready_i    (ar_ready_i),
        .r_valid_i     (r_valid_i),
        .r_data_i      (r_data_i),
        .r_ready_o     (r_ready_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .commite_o     (commite_o),
        .ifu_ok_o      (ifu_ok_o),
        .dbg_state_o   (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pres(input string tag, input logic cm, input logic ok,
                              input logic [63:0] pc, input logic [31:0] inst);
        check({tag, "_commite"}, 64'(commite_o), 64'(cm));
        check({tag, "_ifu_ok"},  64'(ifu_ok_o),  64'(ok));
        check({tag, "_pc"},      pc_o,           pc);
        check({tag, "_inst"},    64'(inst_o),    64'(inst));
    endtask

    initial begin
        rst_n         = 1'b1;
        if_id_stall_i = 1'b0;
        id_j_flush    = 1'b0;
        jump_pc_i     = '0;
        ar_ready_i    = 1'b1;
        r_valid_i     = 1'b1;
        r_data_i      = 64'h00000013_00100093;
        step();
        step();
        check("rst_ar_valid", 64'(ar_valid_o), 64'd0);
        check("rst_r_ready",  64'(r_ready_o),  64'd0);
        check("rst_ar_addr",  ar_addr_o,       64'h8000_0000);
        check_pres("rst", 1'b0, 1'b0, 64'h0, 32'h0);

        rst_n = 1'b0;
        step();  // IDLE -> ADDR
        check("f1_ar_valid", 64'(ar_valid_o), 64'd1);
        check("f1_ar_addr",  ar_addr_o,       64'h8000_0000);
        step();  // ADDR -> DATA
        check("f1_r_ready",  64'(r_ready_o),  64'd1);
        check("f1_ar_low",   64'(ar_valid_o), 64'd0);
        check("f1_no_cm",    64'(commite_o),  64'd0);
        step();  // capture low word
        check_pres("f1", 1'b1, 1'b1, 64'h8000_0000, 32'h0010_0093);
        step();  // consumed, advance
        check_pres("f1_done", 1'b0, 1'b0, 64'h8000_0000, 32'h0);
        check("f2_ar_addr",  ar_addr_o,       64'h8000_0004);
        check("f2_ar_valid", 64'(ar_valid_o), 64'd1);
        step();  // DATA
        step();  // capture high word
        check_pres("f2", 1'b1, 1'b1, 64'h8000_0004, 32'h0000_0013);
        if_id_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pres("f2_stall", 1'b1, 1'b0, 64'h8000_0004, 32'h0000_0013);
            check("f2_stall_ar", 64'(ar_valid_o), 64'd0);
        end
        if_id_stall_i = 1'b0;
        step();
        check("f3_ar_addr", ar_addr_o,       64'h8000_0008);
        check("f3_ar_valid", 64'(ar_valid_o), 64'd1);
        check("f3_no_cm",   64'(commite_o),  64'd0);

        // Redirect while waiting for data; the late response must be dropped.
        r_valid_i = 1'b0;
        step();  // DATA
        id_j_flush = 1'b1;
        jump_pc_i  = 64'h8000_1000;
        step();
        id_j_flush = 1'b0;
        check("kd_r_ready", 64'(r_ready_o), 64'd1);
        check("kd_pc_tgt",  ar_addr_o,      64'h8000_1000);
        r_valid_i = 1'b1;
        step();  // stale beat dropped
        check("kd_no_cm",    64'(commite_o),  64'd0);
        check("kd_no_ok",    64'(ifu_ok_o),   64'd0);
        check("kd_ar_valid", 64'(ar_valid_o), 64'd1);
        check("kd_ar_addr",  ar_addr_o,       64'h8000_1000);
        step();
        step();
        check_pres("kd_refetch", 1'b1, 1'b1, 64'h8000_1000, 32'h0010_0093);

        // Redirect during a stalled hold.
        if_id_stall_i = 1'b1;
        id_j_flush    = 1'b1;
        jump_pc_i     = 64'h8000_3000;
        step();
        id_j_flush    = 1'b0;
        if_id_stall_i = 1'b0;
        check("kh_commite",  64'(commite_o),  64'd0);
        check("kh_inst",     64'(inst_o),     64'd0);
        check("kh_ar_valid", 64'(ar_valid_o), 64'd1);
        check("kh_ar_addr",  ar_addr_o,       64'h8000_3000);

        // Redirect on the same edge as the request handshake.
        r_valid_i  = 1'b0;
        id_j_flush = 1'b1;
        jump_pc_i  = 64'h8000_2004;
        step();
        id_j_flush = 1'b0;
        check("ka_r_ready", 64'(r_ready_o), 64'd1);
        r_valid_i = 1'b1;
        r_data_i  = 64'hAAAAAAAA_BBBBBBBB;
        step();
        check("ka_dropped",  64'(commite_o),  64'd0);
        check("ka_ar_addr",  ar_addr_o,       64'h8000_2004);
        check("ka_ar_valid", 64'(ar_valid_o), 64'd1);
        step();
        step();
        check_pres("ka_refetch", 1'b1, 1'b1, 64'h8000_2004, 32'hAAAA_AAAA);

        // Asynchronous reset in the middle of a read.
        step();  // ADDR at 0x80002008
        check("rs_ar_addr", ar_addr_o, 64'h8000_2008);
        r_valid_i = 1'b0;
        step();  // DATA
        check("rs_in_data", 64'(r_ready_o), 64'd1);
        #2;
        rst_n = 1'b1;
        #1;
        check("rs_ar_valid", 64'(ar_valid_o), 64'd0);
        check("rs_r_ready",  64'(r_ready_o),  64'd0);
        check("rs_ar_addr",  ar_addr_o,       64'h8000_0000);
        check_pres("rs", 1'b0, 1'b0, 64'h0, 32'h0);
        r_valid_i  = 1'b1;
        ar_ready_i = 1'b0;
        step();
        rst_n = 1'b0;
        step();  // IDLE -> ADDR with a stray r_valid_i
        check("rs2_ar_valid", 64'(ar_valid_o), 64'd1);
        check("rs2_ar_addr",  ar_addr_o,       64'h8000_0000);
        check("rs2_r_ready",  64'(r_ready_o),  64'd0);

        // Address change before acceptance.
        id_j_flush = 1'b1;
        jump_pc_i  = 64'h8000_4000;
        step();
        id_j_flush = 1'b0;
        check("ke_ar_valid", 64'(ar_valid_o), 64'd1);
        check("ke_ar_addr",  ar_addr_o,       64'h8000_4000);
        check("ke_no_cm",    64'(commite_o),  64'd0);
        check("ke_r_ready",  64'(r_ready_o),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
